// File: rtl/timer_clint_pkg.sv
// rtl/timer_clint_pkg.sv - shared address map, widths and register decode for the core-local timer
package timer_clint_pkg;

    localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] CLINT_CTRL_ADDR     = 16'hBFF0;
    localparam logic [15:0] CLINT_MTIME_ADDR    = 16'hBFF8;

    localparam int CLINT_TIMER_WIDTH = 64;
    localparam int CLINT_PRESC_WIDTH = 16;

    typedef logic [CLINT_TIMER_WIDTH-1:0] timer_t;

    typedef struct packed {
        logic                         en;
        logic [30-CLINT_PRESC_WIDTH:0] rsvd;
        logic [CLINT_PRESC_WIDTH-1:0] div;
    } clint_ctrl_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_CTRL,
        SEL_MTIME_LO,
        SEL_MTIME_HI
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [4:0] idx;
    } reg_dec_t;

    // Anything not explicitly mapped (including misaligned addresses and
    // harts beyond num_procs) decodes to SEL_NONE and becomes an error response.
    function automatic reg_dec_t decode_addr(input logic [15:0] addr, input int num_procs);
        reg_dec_t d;
        d.sel = SEL_NONE;
        d.idx = '0;
        if (addr[1:0] == 2'b00) begin
            if (addr == CLINT_CTRL_ADDR) begin
                d.sel = SEL_CTRL;
            end else if (addr == CLINT_MTIME_ADDR) begin
                d.sel = SEL_MTIME_LO;
            end else if (addr == CLINT_MTIME_ADDR + 16'd4) begin
                d.sel = SEL_MTIME_HI;
            end else if (addr < CLINT_MSIP_BASE + 16'(4 * num_procs)) begin
                d.sel = SEL_MSIP;
                d.idx = addr[6:2];
            end else if (addr >= CLINT_MTIMECMP_BASE &&
                         addr < CLINT_MTIMECMP_BASE + 16'(8 * num_procs)) begin
                d.sel = addr[2] ? SEL_CMP_HI : SEL_CMP_LO;
                d.idx = addr[7:3];
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/timer_clint_if.sv
// rtl/timer_clint_if.sv - register request/response port of the core-local timer
interface timer_clint_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/timer_clint_prescaler.sv
// rtl/timer_clint_prescaler.sv - mtime tick prescaler, one tick every div+1 enabled cycles
// Ports: clk, rstn (sync active-low), en, div, clr (restart count) -> tick
module timer_clint_prescaler #(
    parameter int PRESC_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic [PRESC_WIDTH-1:0] div,
    input  logic                   clr,
    output logic                   tick
);

    logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + PRESC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_clint.sv
// rtl/timer_clint.sv - core-local timer: mtime, prescaler, per-hart mtimecmp/msip behind a req/rsp port
// Ports: clk, rstn (sync active-low), bus (register req/rsp, slave side),
//        mtime_out (current mtime), timer_int (mtime >= mtimecmp[i]), sw_int (msip[i])
module timer_clint
    import timer_clint_pkg::*;
#(
    parameter int NUM_PROCS   = 4,
    parameter int TIMER_WIDTH = CLINT_TIMER_WIDTH,
    parameter int PRESC_WIDTH = CLINT_PRESC_WIDTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    timer_clint_if.slave           bus,
    output logic [TIMER_WIDTH-1:0] mtime_out,
    output logic [NUM_PROCS-1:0]   timer_int,
    output logic [NUM_PROCS-1:0]   sw_int
);

    logic [TIMER_WIDTH-1:0] mtime_q, mtime_d;
    logic [TIMER_WIDTH-1:0] mtimecmp_q [NUM_PROCS];
    logic [NUM_PROCS-1:0]   msip_q;
    logic [NUM_PROCS-1:0]   timer_int_q;
    logic                   en_q;
    logic [PRESC_WIDTH-1:0] div_q;
    logic                   rsp_valid_q;
    logic [31:0]            rsp_rdata_q;
    logic                   rsp_err_q;

    logic        accept;
    logic        wr;
    logic        tick;
    logic [31:0] rd_data;
    reg_dec_t    dec;

    // Hi words hold only the upper TIMER_WIDTH-32 bits; the rest read as 0.
    function automatic logic [31:0] hi_word(input logic [TIMER_WIDTH-1:0] v);
        return 32'(v >> 32);
    endfunction

    function automatic logic [TIMER_WIDTH-1:0] with_lo(input logic [TIMER_WIDTH-1:0] v,
                                                       input logic [31:0] w);
        return {v[TIMER_WIDTH-1:32], w};
    endfunction

    function automatic logic [TIMER_WIDTH-1:0] with_hi(input logic [TIMER_WIDTH-1:0] v,
                                                       input logic [31:0] w);
        return {w[TIMER_WIDTH-33:0], v[31:0]};
    endfunction

    // A new request can only be taken once the previous response is gone
    // or is being consumed in this same cycle.
    assign bus.req_ready = !(rsp_valid_q && !bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    assign dec           = decode_addr(bus.req_addr, NUM_PROCS);
    assign wr            = accept && bus.req_we && (dec.sel != SEL_NONE);

    timer_clint_prescaler #(
        .PRESC_WIDTH(PRESC_WIDTH)
    ) u_presc (
        .clk (clk),
        .rstn(rstn),
        .en  (en_q),
        .div (div_q),
        .clr (wr && dec.sel == SEL_CTRL),
        .tick(tick)
    );

    always_comb begin
        rd_data = '0;
        case (dec.sel)
            SEL_MSIP: begin
                for (int i = 0; i < NUM_PROCS; i++) begin
                    if (dec.idx == 5'(i)) rd_data = {31'b0, msip_q[i]};
                end
            end
            SEL_CMP_LO: begin
                for (int i = 0; i < NUM_PROCS; i++) begin
                    if (dec.idx == 5'(i)) rd_data = mtimecmp_q[i][31:0];
                end
            end
            SEL_CMP_HI: begin
                for (int i = 0; i < NUM_PROCS; i++) begin
                    if (dec.idx == 5'(i)) rd_data = hi_word(mtimecmp_q[i]);
                end
            end
            SEL_CTRL:     rd_data = {en_q, 31'(div_q)};
            SEL_MTIME_LO: rd_data = mtime_q[31:0];
            SEL_MTIME_HI: rd_data = hi_word(mtime_q);
            default:      rd_data = '0;
        endcase
    end

    // Software writes to mtime win over the tick, and a lo write never carries into hi.
    always_comb begin
        mtime_d = mtime_q;
        if (wr && dec.sel == SEL_MTIME_LO) begin
            mtime_d = with_lo(mtime_q, bus.req_wdata);
        end else if (wr && dec.sel == SEL_MTIME_HI) begin
            mtime_d = with_hi(mtime_q, bus.req_wdata);
        end else if (tick) begin
            mtime_d = mtime_q + TIMER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mtime_q     <= '0;
            msip_q      <= '0;
            timer_int_q <= '0;
            en_q        <= 1'b1;
            div_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            for (int i = 0; i < NUM_PROCS; i++) mtimecmp_q[i] <= '1;
        end else begin
            mtime_q <= mtime_d;

            for (int i = 0; i < NUM_PROCS; i++) begin
                timer_int_q[i] <= (mtime_q >= mtimecmp_q[i]);
                if (wr && dec.idx == 5'(i)) begin
                    if (dec.sel == SEL_MSIP)   msip_q[i]     <= bus.req_wdata[0];
                    if (dec.sel == SEL_CMP_LO) mtimecmp_q[i] <= with_lo(mtimecmp_q[i], bus.req_wdata);
                    if (dec.sel == SEL_CMP_HI) mtimecmp_q[i] <= with_hi(mtimecmp_q[i], bus.req_wdata);
                end
            end

            if (wr && dec.sel == SEL_CTRL) begin
                en_q  <= bus.req_wdata[31];
                div_q <= bus.req_wdata[PRESC_WIDTH-1:0];
            end

            if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= (dec.sel == SEL_NONE);
                rsp_rdata_q <= bus.req_we ? 32'b0 : rd_data;
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign mtime_out     = mtime_q;
    assign timer_int     = timer_int_q;
    // msip is already a register; exposing it directly gives one cycle from accept.
    assign sw_int        = msip_q;

endmodule

// File: tb/tb_timer_clint.sv
// tb/tb_timer_clint.sv - directed self-checking bench for timer_clint
module tb_timer_clint;

    logic        clk;
    logic        rstn;
    logic [63:0] mtime_out;
    logic [3:0]  timer_int;
    logic [3:0]  sw_int;

    int checks   = 0;
    int failures = 0;

    timer_clint_if bif();

    timer_clint #(
        .NUM_PROCS  (4),
        .TIMER_WIDTH(64),
        .PRESC_WIDTH(16)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bif),
        .mtime_out(mtime_out),
        .timer_int(timer_int),
        .sw_int   (sw_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction with rsp_ready held high; returns at the negedge where the response is visible.
    task automatic xfer(input logic we, input logic [15:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        @(negedge clk);
        bif.req_valid = 1'b1;
        bif.req_we    = we;
        bif.req_addr  = a;
        bif.req_wdata = d;
        while (!bif.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bif.req_valid = 1'b0;
        @(negedge clk);
        check("rsp_valid_after_accept", 64'(bif.rsp_valid), 64'd1);
        rd = bif.rsp_rdata;
        er = bif.rsp_err;
    endtask

    logic [31:0] rd, rd2;
    logic        er;
    logic [63:0] v [9];
    logic        found;

    initial begin
        rstn          = 1'b0;
        bif.req_valid = 1'b0;
        bif.req_we    = 1'b0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
        bif.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_mtime", mtime_out, 64'd0);
        check("rst_timer_int", 64'(timer_int), 64'd0);
        check("rst_sw_int", 64'(sw_int), 64'd0);
        check("rst_rsp_valid", 64'(bif.rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(bif.rsp_err), 64'd0);
        check("rst_rsp_rdata", 64'(bif.rsp_rdata), 64'd0);
        check("rst_req_ready", 64'(bif.req_ready), 64'd1);

        // DIV=0: one increment per cycle after reset release
        rstn = 1'b1;
        @(negedge clk); check("count_1", mtime_out, 64'd1);
        @(negedge clk); check("count_2", mtime_out, 64'd2);
        @(negedge clk); check("count_3", mtime_out, 64'd3);
        check("count_timer_int", 64'(timer_int), 64'd0);

        xfer(1'b0, 16'hBFF0, 32'h0, rd, er);
        check("ctrl_reset_read", 64'(rd), 64'h8000_0000);
        check("ctrl_reset_err", 64'(er), 64'd0);

        // Freeze, then program mtimecmp[1] = 10 from mtime = 0
        xfer(1'b1, 16'hBFF0, 32'h0000_0000, rd, er);
        xfer(1'b0, 16'hBFF8, 32'h0, rd, er);
        xfer(1'b0, 16'hBFF8, 32'h0, rd2, er);
        check("frozen_read_stable", 64'(rd2), 64'(rd));
        check("frozen_mtime", mtime_out, 64'(rd));
        xfer(1'b1, 16'hBFF8, 32'h0, rd, er);
        xfer(1'b1, 16'h400C, 32'h0, rd, er);
        xfer(1'b1, 16'h4008, 32'd10, rd, er);
        xfer(1'b0, 16'h4008, 32'h0, rd, er);
        check("cmp1_lo_read", 64'(rd), 64'd10);
        xfer(1'b1, 16'hBFF0, 32'h8000_0000, rd, er);
        check("enable_start_mtime", mtime_out, 64'd0);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mtime_out == 64'd10) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("cmp1_mtime_reached", 64'(found), 64'd1);
        check("cmp1_int_at_10", 64'(timer_int), 64'h0);
        @(negedge clk);
        check("cmp1_int_after_10", 64'(timer_int), 64'h2);

        // DIV=3: exactly one tick per four cycles
        xfer(1'b1, 16'hBFF0, 32'h8000_0003, rd, er);
        v[0] = mtime_out;
        for (int i = 1; i < 9; i++) begin
            @(negedge clk);
            v[i] = mtime_out;
        end
        check("div3_hold_3", v[3], v[0]);
        check("div3_step_4", v[4], v[0] + 64'd1);
        check("div3_step_8", v[8], v[0] + 64'd2);

        // mtime lo write on a tick cycle: no increment
        xfer(1'b1, 16'hBFF0, 32'h8000_0000, rd, er);
        xfer(1'b1, 16'hBFF8, 32'h0000_0100, rd, er);
        check("lo_write_no_incr", mtime_out, 64'h100);
        @(negedge clk);
        check("lo_write_then_count", mtime_out, 64'h101);

        // Wrap: mtime = ..FE, cmp[0] = all ones
        xfer(1'b1, 16'hBFF0, 32'h0000_0000, rd, er);
        xfer(1'b1, 16'hBFFC, 32'hFFFF_FFFF, rd, er);
        xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFE, rd, er);
        xfer(1'b1, 16'h4004, 32'hFFFF_FFFF, rd, er);
        xfer(1'b1, 16'h4000, 32'hFFFF_FFFF, rd, er);
        xfer(1'b1, 16'hBFF0, 32'h8000_0000, rd, er);
        check("wrap_fe", mtime_out, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        check("wrap_ff", mtime_out, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wrap_int_fe", 64'(timer_int), 64'h2);
        @(negedge clk);
        check("wrap_zero", mtime_out, 64'd0);
        check("wrap_int_ff", 64'(timer_int), 64'hF);
        @(negedge clk);
        check("wrap_int_zero", 64'(timer_int), 64'h0);

        // Software interrupt
        xfer(1'b1, 16'h0008, 32'h1, rd, er);
        check("msip2_set", 64'(sw_int), 64'h4);
        xfer(1'b0, 16'h0008, 32'h0, rd, er);
        check("msip2_read", 64'(rd), 64'd1);
        xfer(1'b1, 16'h0008, 32'h0, rd, er);
        check("msip2_clear", 64'(sw_int), 64'h0);

        // Error responses
        xfer(1'b0, 16'h2000, 32'h0, rd, er);
        check("unmapped_err", 64'(er), 64'd1);
        check("unmapped_rdata", 64'(rd), 64'd0);
        xfer(1'b0, 16'h0002, 32'h0, rd, er);
        check("misaligned_err", 64'(er), 64'd1);
        xfer(1'b1, 16'hBFF4, 32'h0000_0003, rd, er);
        check("ctrl_gap_err", 64'(er), 64'd1);
        xfer(1'b0, 16'hBFF0, 32'h0, rd, er);
        check("ctrl_gap_no_effect", 64'(rd), 64'h8000_0000);
        check("ctrl_read_err", 64'(er), 64'd0);

        // Backpressure: rsp_ready low for 3 cycles, then back-to-back accept
        @(negedge clk);
        bif.rsp_ready = 1'b0;
        bif.req_valid = 1'b1;
        bif.req_we    = 1'b0;
        bif.req_addr  = 16'hBFF0;
        @(posedge clk);
        #1 bif.req_addr = 16'h4008;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", 64'(bif.rsp_valid), 64'd1);
            check("stall_req_ready", 64'(bif.req_ready), 64'd0);
            check("stall_rdata", 64'(bif.rsp_rdata), 64'h8000_0000);
        end
        bif.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bif.req_valid = 1'b0;
        @(negedge clk);
        check("b2b_rsp_valid", 64'(bif.rsp_valid), 64'd1);
        check("b2b_rdata", 64'(bif.rsp_rdata), 64'd10);

        // Reset with a response pending
        xfer(1'b1, 16'h000C, 32'h1, rd, er);
        check("msip3_set", 64'(sw_int), 64'h8);
        @(negedge clk);
        bif.rsp_ready = 1'b0;
        bif.req_valid = 1'b1;
        bif.req_we    = 1'b0;
        bif.req_addr  = 16'hBFF8;
        @(posedge clk);
        #1 bif.req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_rsp_valid", 64'(bif.rsp_valid), 64'd1);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_rsp_valid", 64'(bif.rsp_valid), 64'd0);
        check("midrst_req_ready", 64'(bif.req_ready), 64'd1);
        check("midrst_mtime", mtime_out, 64'd0);
        check("midrst_sw_int", 64'(sw_int), 64'd0);
        bif.rsp_ready = 1'b1;
        rstn = 1'b1;
        xfer(1'b0, 16'h4008, 32'h0, rd, er);
        check("midrst_cmp1_lo", 64'(rd), 64'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
